// File: rtl/sram_stream_reader_if.sv
// Handshake bundle between the stream reader, its SRAM and the downstream consumer.
// master = reader side, slave = SRAM/consumer/controller side.
interface sram_stream_reader_if #(
  parameter int WIDTH = 32,
  parameter int AW    = 5
);
  logic             start;
  logic             busy;
  logic             done;
  logic             sram_ren;
  logic             sram_wen;
  logic [AW-1:0]    sram_addr;
  logic [WIDTH-1:0] sram_q;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_last;

  modport master (
    input  start, sram_q, out_ready,
    output busy, done, sram_ren, sram_wen, sram_addr, out_valid, out_data, out_last
  );
  modport slave (
    output start, sram_q, out_ready,
    input  busy, done, sram_ren, sram_wen, sram_addr, out_valid, out_data, out_last
  );
endinterface

// File: rtl/sram_stream_reader.sv
// Streams N words from a single-port SRAM into a 3-entry FWFT FIFO with
// paced, credit-limited read issue and a valid/ready output.
module sram_stream_reader #(
  parameter int WIDTH  = 32,
  parameter int DEPTH  = 32,
  parameter int N      = 32,
  parameter int II     = 1,
  parameter int BASE   = 0,
  parameter int STRIDE = 1
) (
  input logic clk,
  input logic rst,
  sram_stream_reader_if.master bus
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int PW = (II > 1) ? $clog2(II) : 1;
  localparam int CW = 17;
  localparam logic [AW-1:0] BASE_A = AW'(BASE % DEPTH);
  localparam logic [AW:0]   STEP   = (AW+1)'(STRIDE % DEPTH);
  localparam logic [AW:0]   DEP    = (AW+1)'(DEPTH);
  localparam logic [PW-1:0] PACE_L = PW'(II - 1);
  localparam logic [CW-1:0] LAST_I = CW'(N - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  logic [1:0]       state;
  logic [CW-1:0]    issue_cnt;
  logic [PW-1:0]    pace;
  logic [AW-1:0]    addr, addr_q, next_addr;
  logic [AW:0]      addr_sum;
  logic             inflight, inflight_last, done_r;
  logic [WIDTH-1:0] fifo_d [3];
  logic [2:0]       fifo_l;
  logic [1:0]       rd_ptr, wr_ptr, count;
  logic             issue, last_issue, push, pop, valid;

  // Credit uses registered occupancy only, so out_ready never reaches sram_ren.
  assign issue      = (state == RUN) && (pace == '0) && (({1'b0, count} + {2'b0, inflight}) < 3'd3);
  assign last_issue = (issue_cnt == LAST_I);
  assign push       = inflight;
  assign valid      = (count != 2'd0);
  assign pop        = valid & bus.out_ready;

  assign addr_sum  = {1'b0, addr} + STEP;
  assign next_addr = (addr_sum >= DEP) ? AW'(addr_sum - DEP) : addr_sum[AW-1:0];

  assign bus.busy      = (state != IDLE);
  assign bus.done      = done_r;
  assign bus.sram_ren  = issue;
  assign bus.sram_wen  = 1'b0;
  assign bus.sram_addr = issue ? addr : addr_q;
  assign bus.out_valid = valid;
  assign bus.out_data  = fifo_d[rd_ptr];
  assign bus.out_last  = valid & fifo_l[rd_ptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      issue_cnt     <= '0;
      pace          <= '0;
      addr          <= BASE_A;
      addr_q        <= BASE_A;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
      done_r        <= 1'b0;
    end else begin
      done_r        <= 1'b0;
      inflight      <= issue;
      inflight_last <= issue & last_issue;
      if (pace != '0) pace <= pace - 1'b1;
      case (state)
        IDLE: if (bus.start) begin
          state     <= RUN;
          issue_cnt <= '0;
          pace      <= '0;
          addr      <= BASE_A;
        end
        RUN: if (issue) begin
          addr      <= next_addr;
          addr_q    <= addr;
          issue_cnt <= issue_cnt + 1'b1;
          pace      <= PACE_L;
          if (last_issue) state <= DRAIN;
        end
        DRAIN: if (pop && fifo_l[rd_ptr]) begin
          state  <= IDLE;
          done_r <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Occupancy can never exceed 3: an issue needs count + inflight < 3.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 3; i++) fifo_d[i] <= '0;
      fifo_l <= '0;
      rd_ptr <= 2'd0;
      wr_ptr <= 2'd0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        fifo_d[wr_ptr] <= bus.sram_q;
        fifo_l[wr_ptr] <= inflight_last;
        wr_ptr         <= (wr_ptr == 2'd2) ? 2'd0 : wr_ptr + 2'd1;
      end
      if (pop) rd_ptr <= (rd_ptr == 2'd2) ? 2'd0 : rd_ptr + 2'd1;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: tb/tb_sram_stream_reader.sv
// Directed bench: three reader configurations share one SRAM image (mem[i] = i+10).
module tb_sram_stream_reader;
  localparam int W = 32, D = 32, AW = 5;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0;
  logic [W-1:0] mem [D];
  logic both_seen = 1'b0;

  sram_stream_reader_if #(.WIDTH(W), .AW(AW)) ba ();
  sram_stream_reader_if #(.WIDTH(W), .AW(AW)) bb ();
  sram_stream_reader_if #(.WIDTH(W), .AW(AW)) bc ();

  sram_stream_reader #(.WIDTH(W), .DEPTH(D), .N(4), .II(1), .BASE(0),  .STRIDE(1))
    da (.clk(clk), .rst(rst), .bus(ba.master));
  sram_stream_reader #(.WIDTH(W), .DEPTH(D), .N(3), .II(3), .BASE(30), .STRIDE(1))
    db (.clk(clk), .rst(rst), .bus(bb.master));
  sram_stream_reader #(.WIDTH(W), .DEPTH(D), .N(8), .II(1), .BASE(0),  .STRIDE(1))
    dc (.clk(clk), .rst(rst), .bus(bc.master));

  // Registered-read SRAM models.
  always @(posedge clk) begin
    if (ba.sram_ren) ba.sram_q <= mem[ba.sram_addr];
    if (bb.sram_ren) bb.sram_q <= mem[bb.sram_addr];
    if (bc.sram_ren) bc.sram_q <= mem[bc.sram_addr];
  end

  always @(negedge clk)
    if ((ba.sram_ren && ba.sram_wen) || (bb.sram_ren && bb.sram_wen) || (bc.sram_ren && bc.sram_wen))
      both_seen = 1'b1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  int s, n_iss, n_done, n_junk;
  logic [W-1:0] words [$];
  logic         lasts [$];

  initial begin
    for (int i = 0; i < D; i++) mem[i] = W'(i + 10);
    ba.start = 0; bb.start = 0; bc.start = 0;
    ba.out_ready = 1; bb.out_ready = 1; bc.out_ready = 1;

    // reset state
    @(negedge clk);
    chk("rst busy", ba.busy, 0);
    chk("rst done", ba.done, 0);
    chk("rst ren", ba.sram_ren, 0);
    chk("rst wen", ba.sram_wen, 0);
    chk("rst addr", ba.sram_addr, 0);
    chk("rst valid", ba.out_valid, 0);
    chk("rst last", ba.out_last, 0);
    chk("rst data", ba.out_data, 0);
    chk("rst addr base30", bb.sram_addr, 30);
    @(negedge clk); rst = 1;
    @(negedge clk);

    // A: N=4 II=1; start again in cycle 2 (ignored) and in the done cycle 7 (accepted)
    ba.start = 1;
    @(negedge clk);
    for (int c = 1; c <= 16; c++) begin
      s = (c >= 8) ? 7 : 0;
      chk($sformatf("A ren c%0d", c), ba.sram_ren, (c >= s+1 && c <= s+4));
      if (c >= s+1 && c <= s+4) chk($sformatf("A addr c%0d", c), ba.sram_addr, c-s-1);
      chk($sformatf("A valid c%0d", c), ba.out_valid, (c >= s+3 && c <= s+6));
      if (c >= s+3 && c <= s+6) chk($sformatf("A data c%0d", c), ba.out_data, c-s-3+10);
      chk($sformatf("A last c%0d", c), ba.out_last, (c == s+6));
      chk($sformatf("A done c%0d", c), ba.done, (c == 7 || c == 14));
      chk($sformatf("A busy c%0d", c), ba.busy, ((c >= 1 && c <= 6) || (c >= 8 && c <= 13)));
      ba.start = (c == 2 || c == 7);
      @(negedge clk);
    end

    // B: N=3 II=3 BASE=30 -> issues at 1,4,7 with addresses 30,31,0 (wrap)
    bb.start = 1;
    @(negedge clk);
    bb.start = 0;
    for (int c = 1; c <= 11; c++) begin
      chk($sformatf("B ren c%0d", c), bb.sram_ren, (c == 1 || c == 4 || c == 7));
      if (c == 1) chk("B addr c1", bb.sram_addr, 30);
      if (c == 2) chk("B addr hold c2", bb.sram_addr, 30);
      if (c == 4) chk("B addr c4", bb.sram_addr, 31);
      if (c == 5) chk("B addr hold c5", bb.sram_addr, 31);
      if (c == 7) chk("B addr c7", bb.sram_addr, 0);
      chk($sformatf("B valid c%0d", c), bb.out_valid, (c == 3 || c == 6 || c == 9));
      if (c == 3) chk("B data c3", bb.out_data, 40);
      if (c == 6) chk("B data c6", bb.out_data, 41);
      if (c == 9) chk("B data c9", bb.out_data, 10);
      chk($sformatf("B last c%0d", c), bb.out_last, (c == 9));
      chk($sformatf("B done c%0d", c), bb.done, (c == 10));
      @(negedge clk);
    end

    // C: N=8 with out_ready low through cycle 10 -> 3 issues, then all 8 words in order
    bc.out_ready = 0;
    bc.start = 1;
    @(negedge clk);
    bc.start = 0;
    n_iss = 0; n_done = 0;
    for (int c = 1; c <= 45; c++) begin
      bc.out_ready = (c >= 11);
      if (c <= 10 && bc.sram_ren) n_iss++;
      if (c == 10) begin
        chk("C issues while stalled", n_iss, 3);
        chk("C held valid", bc.out_valid, 1);
        chk("C held data", bc.out_data, 10);
      end
      if (bc.out_valid && bc.out_ready) begin
        words.push_back(bc.out_data);
        lasts.push_back(bc.out_last);
      end
      if (bc.done) n_done++;
      @(negedge clk);
    end
    chk("C word count", words.size(), 8);
    for (int i = 0; i < words.size(); i++) begin
      chk($sformatf("C word%0d", i), words[i], i + 10);
      chk($sformatf("C last%0d", i), lasts[i], (i == 7));
    end
    chk("C done count", n_done, 1);
    chk("C idle after", bc.busy, 0);

    // D: reset in cycle 3 of an N=8 job
    bc.start = 1;
    @(negedge clk);
    bc.start = 0;
    @(negedge clk);
    @(negedge clk);
    rst = 0;
    #1;
    chk("D rst busy", bc.busy, 0);
    chk("D rst done", bc.done, 0);
    chk("D rst ren", bc.sram_ren, 0);
    chk("D rst addr", bc.sram_addr, 0);
    chk("D rst valid", bc.out_valid, 0);
    chk("D rst last", bc.out_last, 0);
    chk("D rst data", bc.out_data, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1;
    n_junk = 0;
    for (int c = 0; c < 15; c++) begin
      if (bc.out_valid || bc.done || bc.sram_ren || bc.busy) n_junk++;
      @(negedge clk);
    end
    chk("D no activity after abort", n_junk, 0);

    chk("ren and wen together", both_seen, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
